// File: rtl/fht_sched_pkg.sv
// Shared state type and bank-ordering helper for the FHT frame scheduler.
package fht_sched_pkg;

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RD_ADDR,
    RD_WAIT,
    RD_HOLD
  } sched_state_t;

  // Banks are filled in bit-reversed order so the FHT sees its input permutation for free.
  function automatic logic [3:0] bank_we(input logic [1:0] bank);
    logic [1:0] rev;
    rev = {bank[0], bank[1]};
    return 4'b0001 << rev;
  endfunction

endpackage

// File: rtl/fht_frame_sched_if.sv
// Bus between the frame scheduler (master) and the four-bank FHT core (slave).
interface fht_frame_sched_if #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 8
);
  logic             oFHT_START;
  logic [D_BIT-2:0] oFHT_DATA;
  logic [A_BIT-1:0] oFHT_ADDR_WR;
  logic [3:0]       oFHT_WE;
  logic [A_BIT-1:0] oFHT_ADDR_RD;
  logic             iFHT_RDY;
  logic [D_BIT-1:0] iFHT_DATA_0;
  logic [D_BIT-1:0] iFHT_DATA_1;
  logic [D_BIT-1:0] iFHT_DATA_2;
  logic [D_BIT-1:0] iFHT_DATA_3;

  modport master (
    output oFHT_START, oFHT_DATA, oFHT_ADDR_WR, oFHT_WE, oFHT_ADDR_RD,
    input  iFHT_RDY, iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2, iFHT_DATA_3
  );

  modport slave (
    input  oFHT_START, oFHT_DATA, oFHT_ADDR_WR, oFHT_WE, oFHT_ADDR_RD,
    output iFHT_RDY, iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2, iFHT_DATA_3
  );
endinterface

// File: rtl/fht_res_reader.sv
// Walks the FHT result banks word by word, waiting out the read latency and
// holding each word until the consumer accepts it. LOAD doubles as idle here.
module fht_res_reader
  import fht_sched_pkg::*;
#(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             res_ready,
  input  logic [D_BIT-1:0] rd_data_0,
  input  logic [D_BIT-1:0] rd_data_1,
  input  logic [D_BIT-1:0] rd_data_2,
  input  logic [D_BIT-1:0] rd_data_3,
  output logic [A_BIT-1:0] rd_addr,
  output logic [A_BIT-1:0] res_addr,
  output logic [D_BIT-1:0] res_data_0,
  output logic [D_BIT-1:0] res_data_1,
  output logic [D_BIT-1:0] res_data_2,
  output logic [D_BIT-1:0] res_data_3,
  output logic             res_valid,
  output logic             res_last,
  output logic             done
);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

  sched_state_t  state;
  logic [LW-1:0] lat_cnt;

  assign done = (state == RD_HOLD) && res_ready && res_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      lat_cnt    <= '0;
      rd_addr    <= '0;
      res_addr   <= '0;
      res_data_0 <= '0;
      res_data_1 <= '0;
      res_data_2 <= '0;
      res_data_3 <= '0;
      res_valid  <= 1'b0;
      res_last   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (go) begin
            rd_addr <= '0;
            state   <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          lat_cnt <= '0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            res_data_0 <= rd_data_0;
            res_data_1 <= rd_data_1;
            res_data_2 <= rd_data_2;
            res_data_3 <= rd_data_3;
            res_addr   <= rd_addr;
            res_last   <= (rd_addr == '1);
            res_valid  <= 1'b1;
            state      <= RD_HOLD;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RD_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            if (res_last) begin
              state <= LOAD;
            end else begin
              rd_addr <= rd_addr + 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: rtl/fht_frame_sched.sv
// Frame scheduler: loads ADC samples into four FHT banks, starts the transform,
// supervises its busy handshake and streams the results out through fht_res_reader.
module fht_frame_sched
  import fht_sched_pkg::*;
#(
  parameter int D_BIT   = 16,
  parameter int A_BIT   = 8,
  parameter int RD_LAT  = 2,
  parameter int BUSY_TO = 16
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic [D_BIT-2:0]   iADC_DATA,
  input  logic               iADC_VALID,
  input  logic               iCLR_FLAGS,
  input  logic               iRES_READY,
  fht_frame_sched_if.master  fht,
  output logic [D_BIT-1:0]   oRES_DATA_0,
  output logic [D_BIT-1:0]   oRES_DATA_1,
  output logic [D_BIT-1:0]   oRES_DATA_2,
  output logic [D_BIT-1:0]   oRES_DATA_3,
  output logic [A_BIT-1:0]   oRES_ADDR,
  output logic               oRES_VALID,
  output logic               oRES_LAST,
  output logic               oBUSY,
  output logic               oOVF,
  output logic               oERR,
  output logic [15:0]        oFRAME_CNT
);
  localparam int CW = A_BIT + 2;
  localparam int TW = $clog2(BUSY_TO + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

  // The top FSM parks in RD_ADDR for the whole read-out; the reader owns the finer RD_* steps.
  sched_state_t     state;
  logic [CW-1:0]    smp_cnt;
  logic [TW-1:0]    to_cnt;
  logic             rd_go;
  logic             rd_done;
  logic             drop;
  logic             timeout;
  logic [A_BIT-1:0] rd_addr;

  assign rd_go   = (state == WAIT_DONE) && fht.iFHT_RDY;
  assign drop    = iADC_VALID && (state != LOAD);
  assign timeout = (state == WAIT_BUSY) && fht.iFHT_RDY && (to_cnt == TO_LAST);
  assign oBUSY   = (state != LOAD);
  assign fht.oFHT_ADDR_RD = rd_addr;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state            <= LOAD;
      smp_cnt          <= '0;
      to_cnt           <= '0;
      oFRAME_CNT       <= '0;
      fht.oFHT_START   <= 1'b0;
      fht.oFHT_WE      <= '0;
      fht.oFHT_DATA    <= '0;
      fht.oFHT_ADDR_WR <= '0;
    end else begin
      fht.oFHT_START <= 1'b0;
      fht.oFHT_WE    <= '0;
      case (state)
        LOAD: begin
          if (iADC_VALID) begin
            fht.oFHT_WE      <= bank_we(smp_cnt[CW-1:A_BIT]);
            fht.oFHT_DATA    <= iADC_DATA;
            fht.oFHT_ADDR_WR <= smp_cnt[A_BIT-1:0];
            smp_cnt          <= smp_cnt + 1'b1;
            if (smp_cnt == '1) state <= START;
          end
        end
        START: begin
          fht.oFHT_START <= 1'b1;
          to_cnt         <= '0;
          state          <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!fht.iFHT_RDY) state <= WAIT_DONE;
          else if (timeout)  state <= LOAD;
          else               to_cnt <= to_cnt + 1'b1;
        end
        WAIT_DONE: begin
          if (rd_go) state <= RD_ADDR;
        end
        RD_ADDR: begin
          if (rd_done) begin
            oFRAME_CNT <= oFRAME_CNT + 16'd1;
            state      <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oOVF <= 1'b0;
      oERR <= 1'b0;
    end else begin
      if (drop)            oOVF <= 1'b1;
      else if (iCLR_FLAGS) oOVF <= 1'b0;
      if (timeout)         oERR <= 1'b1;
      else if (iCLR_FLAGS) oERR <= 1'b0;
    end
  end

  fht_res_reader #(
    .D_BIT (D_BIT),
    .A_BIT (A_BIT),
    .RD_LAT(RD_LAT)
  ) u_reader (
    .clk       (iCLK),
    .rst_n     (iRESET),
    .go        (rd_go),
    .res_ready (iRES_READY),
    .rd_data_0 (fht.iFHT_DATA_0),
    .rd_data_1 (fht.iFHT_DATA_1),
    .rd_data_2 (fht.iFHT_DATA_2),
    .rd_data_3 (fht.iFHT_DATA_3),
    .rd_addr   (rd_addr),
    .res_addr  (oRES_ADDR),
    .res_data_0(oRES_DATA_0),
    .res_data_1(oRES_DATA_1),
    .res_data_2(oRES_DATA_2),
    .res_data_3(oRES_DATA_3),
    .res_valid (oRES_VALID),
    .res_last  (oRES_LAST),
    .done      (rd_done)
  );
endmodule

// File: tb/tb_fht_frame_sched.sv
// Directed bench for fht_frame_sched with a small FHT core model (busy handshake plus pipelined bank reads).
module tb_fht_frame_sched;
  localparam int D_BIT   = 16;
  localparam int A_BIT   = 3;
  localparam int RD_LAT  = 2;
  localparam int BUSY_TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [D_BIT-2:0]  adc_data = '0;
  logic              adc_valid = 1'b0;
  logic              clr_flags = 1'b0;
  logic              res_ready = 1'b0;
  logic [D_BIT-1:0]  res_d0, res_d1, res_d2, res_d3;
  logic [A_BIT-1:0]  res_addr;
  logic              res_valid, res_last, busy, ovf, err;
  logic [15:0]       frame_cnt;

  logic [A_BIT-1:0]  p1 = '0;
  logic [A_BIT-1:0]  p2 = '0;
  bit                fht_stuck = 1'b0;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;

  fht_frame_sched_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) fht_bus ();

  fht_frame_sched #(
    .D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT), .BUSY_TO(BUSY_TO)
  ) dut (
    .iCLK       (clk),
    .iRESET     (rst_n),
    .iADC_DATA  (adc_data),
    .iADC_VALID (adc_valid),
    .iCLR_FLAGS (clr_flags),
    .iRES_READY (res_ready),
    .fht        (fht_bus),
    .oRES_DATA_0(res_d0),
    .oRES_DATA_1(res_d1),
    .oRES_DATA_2(res_d2),
    .oRES_DATA_3(res_d3),
    .oRES_ADDR  (res_addr),
    .oRES_VALID (res_valid),
    .oRES_LAST  (res_last),
    .oBUSY      (busy),
    .oOVF       (ovf),
    .oERR       (err),
    .oFRAME_CNT (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bank contents are a fixed function of bank index and address, delayed RD_LAT cycles.
  function automatic logic [15:0] exp_data(input logic [1:0] b, input logic [2:0] a);
    return {4'hA, 2'b00, b, 5'b00000, a};
  endfunction

  always @(posedge clk) begin
    p1 <= fht_bus.oFHT_ADDR_RD;
    p2 <= p1;
  end

  assign fht_bus.iFHT_DATA_0 = exp_data(2'd0, p2);
  assign fht_bus.iFHT_DATA_1 = exp_data(2'd1, p2);
  assign fht_bus.iFHT_DATA_2 = exp_data(2'd2, p2);
  assign fht_bus.iFHT_DATA_3 = exp_data(2'd3, p2);

  // FHT busy model: ready drops 2 cycles after start and returns 50 cycles later.
  initial begin
    fht_bus.iFHT_RDY = 1'b1;
    forever begin
      @(negedge clk);
      if (fht_bus.oFHT_START && !fht_stuck) begin
        repeat (2) @(posedge clk);
        #1 fht_bus.iFHT_RDY = 1'b0;
        repeat (50) @(posedge clk);
        #1 fht_bus.iFHT_RDY = 1'b1;
      end
    end
  end

  function automatic logic [113:0] out_snapshot();
    return {fht_bus.oFHT_START, fht_bus.oFHT_WE, fht_bus.oFHT_DATA, fht_bus.oFHT_ADDR_WR,
            fht_bus.oFHT_ADDR_RD, res_d0, res_d1, res_d2, res_d3, res_addr, res_valid,
            res_last, busy, ovf, err, frame_cnt};
  endfunction

  task automatic send_samples(input int first, input int count);
    for (int n = 0; n < count; n++) begin
      adc_data  = 15'(first + n);
      adc_valid = 1'b1;
      @(negedge clk);
    end
    adc_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_snapshot() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, required 0", out_snapshot());
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_frame();
    logic [3:0] we_tbl [4];
    we_tbl = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    for (int n = 0; n < 32; n++) begin
      adc_data  = 15'(n);
      adc_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (fht_bus.oFHT_WE !== we_tbl[n / 8] || fht_bus.oFHT_ADDR_WR !== 3'(n % 8) ||
          fht_bus.oFHT_DATA !== 15'(n) || fht_bus.oFHT_START !== 1'b0) begin
        errors++;
        $display("[TB] FAIL load_write %0d: we=%b addr=%0d data=%0d start=%b, required we=%b addr=%0d data=%0d start=0",
                 n, fht_bus.oFHT_WE, fht_bus.oFHT_ADDR_WR, fht_bus.oFHT_DATA, fht_bus.oFHT_START,
                 we_tbl[n / 8], n % 8, n);
      end
    end
    adc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fht_bus.oFHT_START !== 1'b1 || fht_bus.oFHT_WE !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_pulse: start=%b we=%b busy=%b, required start=1 we=0000 busy=1",
               fht_bus.oFHT_START, fht_bus.oFHT_WE, busy);
    end
    @(negedge clk);
    checks++;
    if (fht_bus.oFHT_START !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_width: start=%b, required 0", fht_bus.oFHT_START);
    end
  endtask

  task automatic test_read_frame();
    bit ok;
    int last_cyc = 0;
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_valid(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL read_timeout word %0d: res_valid=0, required 1", k);
        break;
      end
      checks++;
      if (res_addr !== 3'(k) || res_last !== (k == 7)) begin
        errors++;
        $display("[TB] FAIL read_addr word %0d: addr=%0d last=%b, required addr=%0d last=%b",
                 k, res_addr, res_last, k, (k == 7));
      end
      checks++;
      if (res_d0 !== exp_data(2'd0, 3'(k)) || res_d1 !== exp_data(2'd1, 3'(k)) ||
          res_d2 !== exp_data(2'd2, 3'(k)) || res_d3 !== exp_data(2'd3, 3'(k))) begin
        errors++;
        $display("[TB] FAIL read_data word %0d: got %h %h %h %h, required %h %h %h %h", k,
                 res_d0, res_d1, res_d2, res_d3, exp_data(2'd0, 3'(k)), exp_data(2'd1, 3'(k)),
                 exp_data(2'd2, 3'(k)), exp_data(2'd3, 3'(k)));
      end
      if (k > 0) begin
        checks++;
        if (cyc - last_cyc !== RD_LAT + 2) begin
          errors++;
          $display("[TB] FAIL read_spacing word %0d: %0d cycles, required %0d", k, cyc - last_cyc, RD_LAT + 2);
        end
      end
      last_cyc = cyc;
      @(negedge clk);
    end
    checks++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL frame_done: frame_cnt=%0d busy=%b valid=%b, required 1 0 0", frame_cnt, busy, res_valid);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    send_samples(100, 32);
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_valid(ok);
      checks++;
      if (!ok || res_addr !== 3'(k)) begin
        errors++;
        $display("[TB] FAIL bp_addr word %0d: valid=%b addr=%0d, required valid=1 addr=%0d", k, res_valid, res_addr, k);
        break;
      end
      if (k == 3) begin
        res_ready = 1'b0;
        bad = 0;
        repeat (10) begin
          @(negedge clk);
          if (res_valid !== 1'b1 || res_addr !== 3'd3 || fht_bus.oFHT_ADDR_RD !== 3'd3 ||
              res_d0 !== exp_data(2'd0, 3'd3) || res_d3 !== exp_data(2'd3, 3'd3)) bad++;
        end
        checks++;
        if (bad !== 0) begin
          errors++;
          $display("[TB] FAIL bp_hold: %0d unstable cycles, required 0", bad);
        end
        res_ready = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if (frame_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL bp_frame_cnt: got %0d, required 2", frame_cnt);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_initial: got %b, required 0", ovf);
    end
    res_ready = 1'b1;
    send_samples(200, 32);
    repeat (9) @(negedge clk);
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    checks++;
    if (fht_bus.oFHT_WE !== 4'b0000 || ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_drop: we=%b ovf=%b, required we=0000 ovf=1", fht_bus.oFHT_WE, ovf);
    end
    adc_valid = 1'b1;
    clr_flags = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    clr_flags = 1'b0;
    checks++;
    if (ovf !== 1'b1 || fht_bus.oFHT_WE !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL ovf_set_wins: ovf=%b we=%b, required ovf=1 we=0000", ovf, fht_bus.oFHT_WE);
    end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear: got %b, required 0", ovf);
    end
    wait_idle(ok);
    checks++;
    if (!ok || frame_cnt !== 16'd3 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_frame_end: idle=%b frame_cnt=%0d err=%b, required 1 3 0", ok, frame_cnt, err);
    end
  endtask

  task automatic test_timeout();
    fht_stuck = 1'b1;
    send_samples(300, 32);
    @(negedge clk);
    checks++;
    if (fht_bus.oFHT_START !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_start: start=%b, required 1", fht_bus.oFHT_START);
    end
    repeat (BUSY_TO - 1) @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_early: err=%b busy=%b, required err=0 busy=1", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || frame_cnt !== 16'd3) begin
      errors++;
      $display("[TB] FAIL to_fire: err=%b busy=%b frame_cnt=%0d, required 1 0 3", err, busy, frame_cnt);
    end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_clear: err=%b, required 0", err);
    end
    fht_stuck = 1'b0;
  endtask

  task automatic test_reset_midframe();
    send_samples(400, 14);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_snapshot() !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %h, required 0", out_snapshot());
    end
    @(negedge clk);
    rst_n = 1'b1;
    adc_data  = 15'd500;
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    checks++;
    if (fht_bus.oFHT_WE !== 4'b0001 || fht_bus.oFHT_ADDR_WR !== 3'd0 || fht_bus.oFHT_DATA !== 15'd500) begin
      errors++;
      $display("[TB] FAIL midreset_first: we=%b addr=%0d data=%0d, required 0001 0 500",
               fht_bus.oFHT_WE, fht_bus.oFHT_ADDR_WR, fht_bus.oFHT_DATA);
    end
    send_samples(501, 30);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fht_bus.oFHT_START !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_31: busy=%b start=%b, required 0 0", busy, fht_bus.oFHT_START);
    end
    send_samples(531, 1);
    @(negedge clk);
    checks++;
    if (fht_bus.oFHT_START !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_32: start=%b, required 1", fht_bus.oFHT_START);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_frame();
    test_read_frame();
    test_backpressure();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
